// File: rtl/sys_cmd_ctrl.sv
// Command responder for the UART register/ALU protocol: decodes RF write/read and
// ALU commands from received bytes, drives RF/ALU control and pushes response bytes.
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR    = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
  input  logic                      RX_D_VLD,
  output logic                      RF_WR_EN,
  output logic                      RF_RD_EN,
  output logic [RF_ADDR-1:0]        RF_ADDRESS,
  output logic [DATA_WIDTH-1:0]     RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]     RF_RD_DATA,
  input  logic                      RF_RD_DATA_VLD,
  output logic                      ALU_EN,
  output logic [FUN_WIDTH-1:0]      ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  output logic                      CLK_GATE_EN,
  output logic                      TX_FIFO_WR_EN,
  output logic [DATA_WIDTH-1:0]     TX_FIFO_WR_DATA,
  input  logic                      TX_FIFO_FULL
);

  localparam logic [DATA_WIDTH-1:0] CMD_RF_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RF_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_ADDR  = 4'd1,
    S_WR_DATA  = 4'd2,
    S_RD_ADDR  = 4'd3,
    S_RD_WAIT  = 4'd4,
    S_RD_SEND  = 4'd5,
    S_ALU_A    = 4'd6,
    S_ALU_B    = 4'd7,
    S_ALU_FUN  = 4'd8,
    S_ALU_WAIT = 4'd9,
    S_SEND_LO  = 4'd10,
    S_SEND_HI  = 4'd11
  } state_t;

  state_t                    state_r;
  logic [RF_ADDR-1:0]        addr_r;
  logic [DATA_WIDTH-1:0]     rd_data_r;
  logic [2*DATA_WIDTH-1:0]   result_r;

  // Command FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r         <= S_IDLE;
      addr_r          <= '0;
      rd_data_r       <= '0;
      result_r        <= '0;
      RF_WR_EN        <= 1'b0;
      RF_RD_EN        <= 1'b0;
      RF_ADDRESS      <= '0;
      RF_WR_DATA      <= '0;
      ALU_EN          <= 1'b0;
      ALU_FUN         <= '0;
      CLK_GATE_EN     <= 1'b0;
      TX_FIFO_WR_EN   <= 1'b0;
      TX_FIFO_WR_DATA <= '0;
    end else begin
      RF_WR_EN      <= 1'b0;
      RF_RD_EN      <= 1'b0;
      ALU_EN        <= 1'b0;
      TX_FIFO_WR_EN <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              CMD_RF_WR: state_r <= S_WR_ADDR;
              CMD_RF_RD: state_r <= S_RD_ADDR;
              CMD_ALU_OP: begin
                state_r     <= S_ALU_A;
                CLK_GATE_EN <= 1'b1;
              end
              CMD_ALU_NO: begin
                state_r     <= S_ALU_FUN;
                CLK_GATE_EN <= 1'b1;
              end
              default: state_r <= S_IDLE;
            endcase
          end
        end
        S_WR_ADDR: begin
          if (RX_D_VLD) begin
            addr_r  <= RX_P_DATA[RF_ADDR-1:0];
            state_r <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (RX_D_VLD) begin
            RF_WR_EN   <= 1'b1;
            RF_ADDRESS <= addr_r;
            RF_WR_DATA <= RX_P_DATA;
            state_r    <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (RX_D_VLD) begin
            RF_RD_EN   <= 1'b1;
            RF_ADDRESS <= RX_P_DATA[RF_ADDR-1:0];
            state_r    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (RF_RD_DATA_VLD) begin
            rd_data_r <= RF_RD_DATA;
            state_r   <= S_RD_SEND;
          end
        end
        S_RD_SEND: begin
          if (!TX_FIFO_FULL) begin
            TX_FIFO_WR_EN   <= 1'b1;
            TX_FIFO_WR_DATA <= rd_data_r;
            state_r         <= S_IDLE;
          end
        end
        // Operands land in RF locations 0 and 1 where the ALU picks them up.
        S_ALU_A: begin
          if (RX_D_VLD) begin
            RF_WR_EN   <= 1'b1;
            RF_ADDRESS <= '0;
            RF_WR_DATA <= RX_P_DATA;
            state_r    <= S_ALU_B;
          end
        end
        S_ALU_B: begin
          if (RX_D_VLD) begin
            RF_WR_EN   <= 1'b1;
            RF_ADDRESS <= RF_ADDR'(1'b1);
            RF_WR_DATA <= RX_P_DATA;
            state_r    <= S_ALU_FUN;
          end
        end
        S_ALU_FUN: begin
          if (RX_D_VLD) begin
            ALU_EN  <= 1'b1;
            ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
            state_r <= S_ALU_WAIT;
          end
        end
        S_ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            result_r    <= ALU_OUT;
            CLK_GATE_EN <= 1'b0;
            state_r     <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (!TX_FIFO_FULL) begin
            TX_FIFO_WR_EN   <= 1'b1;
            TX_FIFO_WR_DATA <= result_r[DATA_WIDTH-1:0];
            state_r         <= S_SEND_HI;
          end
        end
        S_SEND_HI: begin
          if (!TX_FIFO_FULL) begin
            TX_FIFO_WR_EN   <= 1'b1;
            TX_FIFO_WR_DATA <= result_r[2*DATA_WIDTH-1:DATA_WIDTH];
            state_r         <= S_IDLE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          CLK_GATE_EN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Self-checking bench for sys_cmd_ctrl: command table plus hand-written corner
// sequences, with output events compared against a queue of expected events.
module tb_sys_cmd_ctrl;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic        RF_WR_EN;
  logic        RF_RD_EN;
  logic [3:0]  RF_ADDRESS;
  logic [7:0]  RF_WR_DATA;
  logic [7:0]  RF_RD_DATA;
  logic        RF_RD_DATA_VLD;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        CLK_GATE_EN;
  logic        TX_FIFO_WR_EN;
  logic [7:0]  TX_FIFO_WR_DATA;
  logic        TX_FIFO_FULL;

  sys_cmd_ctrl #(.DATA_WIDTH(8), .RF_ADDR(4), .FUN_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
    .RF_ADDRESS(RF_ADDRESS), .RF_WR_DATA(RF_WR_DATA),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .CLK_GATE_EN(CLK_GATE_EN),
    .TX_FIFO_WR_EN(TX_FIFO_WR_EN), .TX_FIFO_WR_DATA(TX_FIFO_WR_DATA),
    .TX_FIFO_FULL(TX_FIFO_FULL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Event encoding: {kind, 4'h0, addr/fun, data}; kind 1=RF wr, 2=RF rd, 3=ALU_EN, 4=TX push.
  typedef struct packed {
    logic [31:0]  bytes;
    logic [2:0]   nb;
    logic [7:0]   rd;
    logic [15:0]  alu;
    logic [99:0]  evs;
    logic [2:0]   ne;
  } vec_t;

  vec_t        vecs [7];
  logic [19:0] exp_q [$];
  int          checks;
  int          errors;
  int          rd_cnt;
  int          alu_cnt;
  logic [7:0]  rd_resp;
  logic [15:0] alu_resp;
  logic [7:0]  last_tx;

  function automatic logic [19:0] ew(input logic [3:0] a, input logic [7:0] d);
    return {4'd1, 4'd0, a, d};
  endfunction
  function automatic logic [19:0] er(input logic [3:0] a);
    return {4'd2, 4'd0, a, 8'h00};
  endfunction
  function automatic logic [19:0] ea(input logic [3:0] f);
    return {4'd3, 4'd0, f, 8'h01};
  endfunction
  function automatic logic [19:0] et(input logic [7:0] d);
    return {4'd4, 8'h00, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_ev(input string name, input logic [19:0] got);
    logic [19:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event got=%h expected=none", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
    end
  endtask

  task automatic expect_ev(input logic [19:0] e);
    exp_q.push_back(e);
    if (e[19:16] == 4'd4) last_tx = e[7:0];
  endtask

  // One cycle: sample outputs at negedge, then drive RF/ALU responders and clear RX strobe.
  task automatic tick();
    @(negedge CLK);
    if (RF_WR_EN)      check_ev("rf_wr",   {4'd1, 4'd0, RF_ADDRESS, RF_WR_DATA});
    if (RF_RD_EN)      check_ev("rf_rd",   {4'd2, 4'd0, RF_ADDRESS, 8'h00});
    if (ALU_EN)        check_ev("alu_en",  {4'd3, 4'd0, ALU_FUN, 7'd0, CLK_GATE_EN});
    if (TX_FIFO_WR_EN) check_ev("tx_push", {4'd4, 8'h00, TX_FIFO_WR_DATA});
    RF_RD_DATA_VLD = 1'b0;
    ALU_OUT_VLD    = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        RF_RD_DATA     = rd_resp;
        RF_RD_DATA_VLD = 1'b1;
      end
    end
    if (RF_RD_EN) rd_cnt = 1;
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin
        chk("gate_at_alu_vld", 32'(CLK_GATE_EN), 32'd1);
        ALU_OUT     = alu_resp;
        ALU_OUT_VLD = 1'b1;
      end
    end
    if (ALU_EN) alu_cnt = 2;
    RX_D_VLD = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout pending=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({RF_WR_EN, RF_RD_EN, RF_ADDRESS, RF_WR_DATA, ALU_EN, ALU_FUN,
                CLK_GATE_EN, TX_FIFO_WR_EN, TX_FIFO_WR_DATA});
  endfunction

  initial begin
    checks = 0; errors = 0; rd_cnt = 0; alu_cnt = 0;
    rd_resp = 8'h00; alu_resp = 16'h0000; last_tx = 8'h00;
    RST = 1'b1;
    RX_P_DATA = 8'h00; RX_D_VLD = 1'b0;
    RF_RD_DATA = 8'h00; RF_RD_DATA_VLD = 1'b0;
    ALU_OUT = 16'h0000; ALU_OUT_VLD = 1'b0;
    TX_FIFO_FULL = 1'b0;

    vecs[0] = '{bytes: 32'hAA045500, nb: 3'd3, rd: 8'h00, alu: 16'h0000,
                evs: {ew(4'h4, 8'h55), 80'h0}, ne: 3'd1};
    vecs[1] = '{bytes: 32'hBB040000, nb: 3'd2, rd: 8'h55, alu: 16'h0000,
                evs: {er(4'h4), et(8'h55), 60'h0}, ne: 3'd2};
    vecs[2] = '{bytes: 32'hCCAABB00, nb: 3'd4, rd: 8'h00, alu: 16'h0165,
                evs: {ew(4'h0, 8'hAA), ew(4'h1, 8'hBB), ea(4'h0), et(8'h65), et(8'h01)}, ne: 3'd5};
    vecs[3] = '{bytes: 32'hDD020000, nb: 3'd2, rd: 8'h00, alu: 16'hFFEF,
                evs: {ea(4'h2), et(8'hEF), et(8'hFF), 40'h0}, ne: 3'd3};
    vecs[4] = '{bytes: 32'h5A000000, nb: 3'd1, rd: 8'h00, alu: 16'h0000,
                evs: 100'h0, ne: 3'd0};
    vecs[5] = '{bytes: 32'hAA037E00, nb: 3'd3, rd: 8'h00, alu: 16'h0000,
                evs: {ew(4'h3, 8'h7E), 80'h0}, ne: 3'd1};
    // Trailing 0xAA arrives in RD_WAIT and must be dropped.
    vecs[6] = '{bytes: 32'hBB07AA00, nb: 3'd3, rd: 8'h3C, alu: 16'h0000,
                evs: {er(4'h7), et(8'h3C), 60'h0}, ne: 3'd2};

    idle(2);
    chk("reset_outputs", all_outs(), 32'd0);
    RST = 1'b0;
    idle(2);

    for (int v = 0; v < 7; v++) begin
      rd_resp  = vecs[v].rd;
      alu_resp = vecs[v].alu;
      for (int j = 0; j < int'(vecs[v].ne); j++) expect_ev(vecs[v].evs[99 - 20*j -: 20]);
      for (int j = 0; j < int'(vecs[v].nb); j++) send_byte(vecs[v].bytes[31 - 8*j -: 8]);
      wait_done("vector", 60);
      idle(3);
      chk("gate_off_after_vector", 32'(CLK_GATE_EN), 32'd0);
    end

    // FIFO full through SEND_LO: no push, data held, then both bytes in order.
    TX_FIFO_FULL = 1'b1;
    alu_resp = 16'hFFEF;
    expect_ev(ea(4'h2));
    send_byte(8'hDD);
    send_byte(8'h02);
    wait_done("full_alu_en", 20);
    idle(12);
    chk("full_no_push", 32'(TX_FIFO_WR_EN), 32'd0);
    chk("full_data_held", 32'(TX_FIFO_WR_DATA), 32'(last_tx));
    expect_ev(et(8'hEF));
    expect_ev(et(8'hFF));
    TX_FIFO_FULL = 1'b0;
    wait_done("full_release", 20);
    idle(3);
    chk("tx_data_hold_after", 32'(TX_FIFO_WR_DATA), 32'h0000_00FF);

    // Reset mid-command after CC,11: only addr0 written, then DD runs normally.
    expect_ev(ew(4'h0, 8'h11));
    send_byte(8'hCC);
    chk("gate_on_after_cc", 32'(CLK_GATE_EN), 32'd1);
    send_byte(8'h11);
    wait_done("abort_opnd", 10);
    RST = 1'b1;
    rd_cnt = 0;
    alu_cnt = 0;
    tick();
    chk("mid_reset_outputs", all_outs(), 32'd0);
    RST = 1'b0;
    idle(2);
    alu_resp = 16'h1234;
    expect_ev(ea(4'h1));
    expect_ev(et(8'h34));
    expect_ev(et(8'h12));
    send_byte(8'hDD);
    send_byte(8'h01);
    wait_done("after_reset_dd", 30);
    idle(3);
    chk("gate_off_final", 32'(CLK_GATE_EN), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
